// File: rtl/int_ctrl_if.sv
// Bus bundle between the interrupt sources / CPU and the interrupt controller.
// The master side drives requests and CPU accesses; the slave side is int_ctrl.
interface int_ctrl_if;
  logic       irq_vblank;
  logic       irq_lcd;
  logic       irq_timer;
  logic       irq_serial;
  logic       irq_joypad;
  logic       if_sel;
  logic       ie_sel;
  logic       cpu_wr;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       irq_ack;
  logic       irq_n;
  logic [7:0] irq_vector;

  modport master (
    output irq_vblank, irq_lcd, irq_timer, irq_serial, irq_joypad,
    output if_sel, ie_sel, cpu_wr, cpu_di, irq_ack,
    input  cpu_do, irq_n, irq_vector
  );

  modport slave (
    input  irq_vblank, irq_lcd, irq_timer, irq_serial, irq_joypad,
    input  if_sel, ie_sel, cpu_wr, cpu_di, irq_ack,
    output cpu_do, irq_n, irq_vector
  );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: latches request pulses into IF, masks with IE and
// presents a registered active-low IRQ plus the restart vector of the winner.
module int_ctrl (
  input  logic         clk,
  input  logic         reset,
  int_ctrl_if.slave    bus
);

  logic [4:0] r_if;
  logic [7:0] r_ie;
  logic       r_irq_n;
  logic [7:0] r_irq_vector;

  logic [4:0] w_req;
  logic [4:0] w_ack_clr;
  logic [4:0] w_if_next;
  logic [7:0] w_ie_next;
  logic [4:0] w_pending;
  logic [7:0] w_vec_next;

  assign w_req = {bus.irq_joypad, bus.irq_serial, bus.irq_timer,
                  bus.irq_lcd, bus.irq_vblank};

  // Ack clears the bit we last vectored to; a 0x00 vector makes it a no-op.
  always_comb begin
    w_ack_clr = 5'b00000;
    case (r_irq_vector)
      8'h40:   w_ack_clr = 5'b00001;
      8'h48:   w_ack_clr = 5'b00010;
      8'h50:   w_ack_clr = 5'b00100;
      8'h58:   w_ack_clr = 5'b01000;
      8'h60:   w_ack_clr = 5'b10000;
      default: w_ack_clr = 5'b00000;
    endcase
  end

  always_comb begin
    w_if_next = r_if;
    if (bus.irq_ack) begin
      w_if_next = r_if & ~w_ack_clr;
    end
    if (bus.if_sel && bus.cpu_wr) begin
      w_if_next = bus.cpu_di[4:0];
    end
    w_if_next = w_if_next | w_req;
  end

  assign w_ie_next = (bus.ie_sel && bus.cpu_wr) ? bus.cpu_di : r_ie;
  assign w_pending = w_if_next & w_ie_next[4:0];

  // Fixed priority: lowest IF bit wins.
  always_comb begin
    w_vec_next = 8'h00;
    casez (w_pending)
      5'b????1: w_vec_next = 8'h40;
      5'b???10: w_vec_next = 8'h48;
      5'b??100: w_vec_next = 8'h50;
      5'b?1000: w_vec_next = 8'h58;
      5'b10000: w_vec_next = 8'h60;
      default:  w_vec_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if         <= 5'b00000;
      r_ie         <= 8'h00;
      r_irq_n      <= 1'b1;
      r_irq_vector <= 8'h00;
    end else begin
      r_if         <= w_if_next;
      r_ie         <= w_ie_next;
      r_irq_n      <= ~|w_pending;
      r_irq_vector <= w_vec_next;
    end
  end

  assign bus.cpu_do     = bus.if_sel ? {3'b111, r_if} :
                          bus.ie_sel ? r_ie : 8'hFF;
  assign bus.irq_n      = r_irq_n;
  assign bus.irq_vector = r_irq_vector;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed, table-driven bench for int_ctrl with hand-computed expectations,
// plus hand-written sequences for held levels and asynchronous reset.
module tb_int_ctrl;

  logic clk;
  logic reset;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pulse;
    logic       if_wr;
    logic       ie_wr;
    logic [7:0] di;
    logic       ack;
    logic       exp_n;
    logic [7:0] exp_vec;
    logic [7:0] exp_if;
    logic [7:0] exp_ie;
  } vec_t;

  vec_t tbl [22];
  int   testsRun;
  int   testsFailed;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    bus.irq_vblank = 1'b0;
    bus.irq_lcd    = 1'b0;
    bus.irq_timer  = 1'b0;
    bus.irq_serial = 1'b0;
    bus.irq_joypad = 1'b0;
    bus.if_sel     = 1'b0;
    bus.ie_sel     = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_di     = 8'h00;
    bus.irq_ack    = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.irq_vblank = v.pulse[0];
    bus.irq_lcd    = v.pulse[1];
    bus.irq_timer  = v.pulse[2];
    bus.irq_serial = v.pulse[3];
    bus.irq_joypad = v.pulse[4];
    bus.if_sel     = v.if_wr;
    bus.ie_sel     = v.ie_wr;
    bus.cpu_wr     = v.if_wr | v.ie_wr;
    bus.cpu_di     = v.di;
    bus.irq_ack    = v.ack;
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  // Outputs are checked 1 time unit after the edge; reads are combinational.
  task automatic checkOutput(input string tag, input logic exp_n, input logic [7:0] exp_vec,
                             input logic [7:0] exp_if, input logic [7:0] exp_ie);
    check({tag, " irq_n"}, {7'b0, bus.irq_n}, {7'b0, exp_n});
    check({tag, " irq_vector"}, bus.irq_vector, exp_vec);
    bus.if_sel = 1'b1;
    #1;
    check({tag, " IF read"}, bus.cpu_do, exp_if);
    bus.if_sel = 1'b0;
    bus.ie_sel = 1'b1;
    #1;
    check({tag, " IE read"}, bus.cpu_do, exp_ie);
    bus.ie_sel = 1'b0;
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    clearInputs();

    //            pulse    ifw   iew   di     ack   n     vec    IF     IE
    tbl[0]  = '{5'b00000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h00};
    tbl[1]  = '{5'b00000, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h04};
    tbl[2]  = '{5'b00100, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h50, 8'hE4, 8'h04};
    tbl[3]  = '{5'b00000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'hE0, 8'h04};
    tbl[4]  = '{5'b00000, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h1F};
    tbl[5]  = '{5'b10001, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 8'hF1, 8'h1F};
    tbl[6]  = '{5'b00000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h60, 8'hF0, 8'h1F};
    tbl[7]  = '{5'b00000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'hE0, 8'h1F};
    tbl[8]  = '{5'b00000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h00};
    tbl[9]  = '{5'b00010, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hE2, 8'h00};
    tbl[10] = '{5'b00000, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h48, 8'hE2, 8'h02};
    tbl[11] = '{5'b00000, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 8'h48, 8'hE2, 8'h1F};
    tbl[12] = '{5'b00100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h50, 8'hE4, 8'h1F};
    tbl[13] = '{5'b00100, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h50, 8'hE4, 8'h1F};
    tbl[14] = '{5'b00000, 1'b1, 1'b0, 8'h1F, 1'b1, 1'b0, 8'h40, 8'hFF, 8'h1F};
    tbl[15] = '{5'b00000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h48, 8'hFE, 8'h1F};
    tbl[16] = '{5'b00001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 8'hFD, 8'h1F};
    tbl[17] = '{5'b00000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h00};
    tbl[18] = '{5'b00000, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 8'hE0, 8'hFF};
    tbl[19] = '{5'b00000, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, 8'h40, 8'hFF, 8'hFF};
    tbl[20] = '{5'b00000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00};
    tbl[21] = '{5'b00000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp_n, tbl[i].exp_vec, tbl[i].exp_if, tbl[i].exp_ie);
    end

    // Unselected read returns 0xFF.
    check("idle read", bus.cpu_do, 8'hFF);

    // Held timer level: an ack during the level cannot clear the bit.
    applyStimulus('{5'b00000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h00});
    applyStimulus('{5'b00000, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h04});
    bus.irq_timer = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("level1", 1'b0, 8'h50, 8'hE4, 8'h04);
    bus.irq_timer = 1'b1;
    bus.irq_ack   = 1'b1;
    @(posedge clk);
    #1;
    bus.irq_timer = 1'b0;
    bus.irq_ack   = 1'b0;
    checkOutput("level2", 1'b0, 8'h50, 8'hE4, 8'h04);
    bus.irq_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.irq_ack = 1'b0;
    checkOutput("levelack", 1'b1, 8'h00, 8'hE0, 8'h04);

    // Asynchronous reset mid-sequence with a request in flight.
    applyStimulus('{5'b00000, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h40, 8'hFF, 8'hFF});
    checkOutput("prereset", 1'b0, 8'h40, 8'hFF, 8'hFF);
    @(negedge clk);
    bus.irq_vblank = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("inreset", 1'b1, 8'h00, 8'hE0, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.irq_vblank = 1'b0;
    checkOutput("postreset", 1'b1, 8'h00, 8'hE0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
